// File: rtl/dcal_pkg.sv
// dcal_pkg: shared calendar definitions for the D-day controller.
// Holds the packed date layout (year[22:9] month[8:5] day[4:0]), the legal
// year/month limits and the edit FSM state encoding.
package dcal_pkg;

    localparam int YEAR_W    = 14;
    localparam int MONTH_W   = 4;
    localparam int DAY_W     = 5;
    localparam int DATE_W    = YEAR_W + MONTH_W + DAY_W;
    localparam int DAY_LSB   = 0;
    localparam int MONTH_LSB = DAY_LSB + DAY_W;
    localparam int YEAR_LSB  = MONTH_LSB + MONTH_W;

    localparam logic [YEAR_W-1:0]  YEAR_MIN  = 14'd1;
    localparam logic [YEAR_W-1:0]  YEAR_MAX  = 14'd9999;
    localparam logic [MONTH_W-1:0] MONTH_MIN = 4'd1;
    localparam logic [MONTH_W-1:0] MONTH_MAX = 4'd12;

    typedef struct packed {
        logic [YEAR_W-1:0]  year;
        logic [MONTH_W-1:0] month;
        logic [DAY_W-1:0]   day;
    } date_t;

    // The encoding doubles as the field_sel output value.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ED_YEAR  = 2'd1,
        ED_MONTH = 2'd2,
        ED_DAY   = 2'd3
    } dstate_e;

endpackage

// File: rtl/days_in_month.sv
// days_in_month: combinational month length (28..31) for a given year and
// month using the Gregorian leap rule.
// Ports:
//   year_i  - calendar year
//   month_i - month 1..12 (out-of-range months report 31)
//   dim_o   - number of days in that month
module days_in_month
    import dcal_pkg::*;
(
    input  logic [YEAR_W-1:0]  year_i,
    input  logic [MONTH_W-1:0] month_i,
    output logic [DAY_W-1:0]   dim_o
);

    logic leap;

    always_comb begin
        leap = (year_i[1:0] == 2'b00) &&
               (((year_i % 14'd100) != 14'd0) || ((year_i % 14'd400) == 14'd0));
        case (month_i)
            4'd2:                      dim_o = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   dim_o = 5'd30;
            default:                   dim_o = 5'd31;
        endcase
    end

endmodule

// File: rtl/dday_set_ctrl.sv
// dday_set_ctrl: button-driven editor for the D-day target date.
// btn_mode enters edit (year -> month -> day) and commits from the day field;
// btn_up/btn_dn step the selected field with wrap; btn_cancel or edit
// inactivity abandons the edit. set_date only changes on commit or reset.
// Output contract: set_load is high for exactly the one cycle in which
// set_date first shows a newly committed value; set_valid stays high after.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   btn_mode/up/dn/cancel         - one-cycle button pulses
//   now_date                      - current date, seed for the first edit
//   set_date / set_valid/set_load - committed target and its status
//   work_date / field_sel         - edit buffer and selected field (state)
module dday_set_ctrl
    import dcal_pkg::*;
#(
    parameter logic [31:0]       TIMEOUT_CYC = 32'd50_000_000,
    parameter logic [DATE_W-1:0] RST_DATE    = {14'd2000, 4'd1, 5'd1}
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_mode,
    input  logic              btn_up,
    input  logic              btn_dn,
    input  logic              btn_cancel,
    input  logic [DATE_W-1:0] now_date,
    output logic [DATE_W-1:0] set_date,
    output logic [DATE_W-1:0] work_date,
    output logic [1:0]        field_sel,
    output logic              set_valid,
    output logic              set_load
);

    dstate_e     state_q, state_d;
    date_t       work_q, work_d;
    date_t       set_q;
    logic        valid_q, load_q;
    logic [31:0] cnt_q, cnt_d;

    logic  in_edit, any_btn, timeout, abort, edit_en, step_up, step_dn;
    logic  enter, commit;
    date_t src, base;
    logic [DAY_W-1:0] dim, day_n;

    assign in_edit = (state_q != IDLE);
    assign any_btn = btn_mode | btn_up | btn_dn | btn_cancel;
    // A button in the expiry cycle counts as activity, so it wins over timeout.
    assign timeout = in_edit && !any_btn && (cnt_q == TIMEOUT_CYC - 32'd1);
    assign abort   = in_edit && (btn_cancel || timeout);
    assign edit_en = in_edit && !btn_cancel && !btn_mode;
    // up and dn together cancel each other out.
    assign step_up = btn_up & ~btn_dn;
    assign step_dn = btn_dn & ~btn_up;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (btn_mode) state_d = ED_YEAR;
            ED_YEAR:  if (abort) state_d = IDLE; else if (btn_mode) state_d = ED_MONTH;
            ED_MONTH: if (abort) state_d = IDLE; else if (btn_mode) state_d = ED_DAY;
            ED_DAY:   if (abort || btn_mode) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        field_sel = state_q;
        enter     = (state_q == IDLE) && btn_mode;
        commit    = (state_q == ED_DAY) && btn_mode && !btn_cancel;
    end

    // Edit datapath: year/month are resolved first, then a single month-length
    // lookup on the resulting year/month drives both day stepping and the clamp,
    // so a year or month change lands an in-range day in the same cycle.
    days_in_month u_dim (
        .year_i  (base.year),
        .month_i (base.month),
        .dim_o   (dim)
    );

    always_comb begin
        src  = valid_q ? set_q : date_t'(now_date);
        base = work_q;
        if (enter) begin
            base = src;
            if (src.year < YEAR_MIN)        base.year = YEAR_MIN;
            else if (src.year > YEAR_MAX)   base.year = YEAR_MAX;
            if (src.month < MONTH_MIN)      base.month = MONTH_MIN;
            else if (src.month > MONTH_MAX) base.month = MONTH_MAX;
        end else if (edit_en && state_q == ED_YEAR) begin
            if (step_up)      base.year = (work_q.year >= YEAR_MAX) ? YEAR_MIN : work_q.year + 1'b1;
            else if (step_dn) base.year = (work_q.year <= YEAR_MIN) ? YEAR_MAX : work_q.year - 1'b1;
        end else if (edit_en && state_q == ED_MONTH) begin
            if (step_up)      base.month = (work_q.month >= MONTH_MAX) ? MONTH_MIN : work_q.month + 1'b1;
            else if (step_dn) base.month = (work_q.month <= MONTH_MIN) ? MONTH_MAX : work_q.month - 1'b1;
        end

        day_n = base.day;
        if (edit_en && state_q == ED_DAY && step_up)
            day_n = (work_q.day >= dim) ? 5'd1 : work_q.day + 1'b1;
        else if (edit_en && state_q == ED_DAY && step_dn)
            day_n = (work_q.day <= 5'd1) ? dim : work_q.day - 1'b1;
        else if (base.day == 5'd0)
            day_n = 5'd1;
        else if (base.day > dim)
            day_n = dim;

        work_d = work_q;
        if (enter || edit_en)
            work_d = '{year: base.year, month: base.month, day: day_n};
    end

    // Inactivity counter is held at zero outside edit and on any button.
    always_comb begin
        if (!in_edit || any_btn || timeout) cnt_d = 32'd0;
        else                                cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            work_q  <= date_t'(RST_DATE);
            set_q   <= date_t'(RST_DATE);
            valid_q <= 1'b0;
            load_q  <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            work_q <= work_d;
            cnt_q  <= cnt_d;
            load_q <= commit;
            if (commit) begin
                set_q   <= work_q;
                valid_q <= 1'b1;
            end
        end
    end

    assign set_date  = set_q;
    assign work_date = work_q;
    assign set_valid = valid_q;
    assign set_load  = load_q;

endmodule

// File: tb/tb_dday_set_ctrl.sv
module tb_dday_set_ctrl;

    localparam logic [3:0] B_NONE = 4'b0000;
    localparam logic [3:0] B_DN   = 4'b0001;
    localparam logic [3:0] B_UP   = 4'b0010;
    localparam logic [3:0] B_MODE = 4'b0100;
    localparam logic [3:0] B_CAN  = 4'b1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_mode = 1'b0, btn_up = 1'b0, btn_dn = 1'b0, btn_cancel = 1'b0;
    logic [22:0] now_date = '0;
    logic [22:0] set_date, work_date;
    logic [1:0]  field_sel;
    logic        set_valid, set_load;

    int n_vec = 0;
    int n_err = 0;
    int load_cnt = 0;

    logic [24:0] exp_q[$];
    string       tag_q[$];

    dday_set_ctrl #(.TIMEOUT_CYC(32'd16)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_mode   (btn_mode),
        .btn_up     (btn_up),
        .btn_dn     (btn_dn),
        .btn_cancel (btn_cancel),
        .now_date   (now_date),
        .set_date   (set_date),
        .work_date  (work_date),
        .field_sel  (field_sel),
        .set_valid  (set_valid),
        .set_load   (set_load)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    always @(negedge clk) if (set_load) load_cnt++;

    function automatic logic [22:0] mk_date(input int y, input int m, input int d);
        logic [31:0] yy, mm, dd;
        yy = y; mm = m; dd = d;
        return {yy[13:0], mm[3:0], dd[4:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // scoreboard pop: compare {field_sel, work_date} against the oldest expectation
    task automatic pop_cmp();
        logic [24:0] e;
        string t;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, {7'd0, field_sel, work_date}, {7'd0, e});
        end
    endtask

    // driver: one-cycle button pulse, expectation pushed when driven
    task automatic apply(input logic [3:0] b, input logic [1:0] fs, input logic [22:0] wd,
                         input string tag);
        exp_q.push_back({fs, wd});
        tag_q.push_back(tag);
        @(negedge clk);
        {btn_cancel, btn_mode, btn_up, btn_dn} = b;
        @(posedge clk); #1;
        {btn_cancel, btn_mode, btn_up, btn_dn} = B_NONE;
        pop_cmp();
    endtask

    task automatic idle(input int n, input logic [1:0] fs, input logic [22:0] wd,
                        input string tag);
        exp_q.push_back({fs, wd});
        tag_q.push_back(tag);
        repeat (n) @(posedge clk);
        #1;
        pop_cmp();
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        do_reset(2);

        // reset state
        check("rst_set_date", {9'd0, set_date}, {9'd0, mk_date(2000, 1, 1)});
        check("rst_work_date", {9'd0, work_date}, {9'd0, mk_date(2000, 1, 1)});
        check("rst_valid", {31'd0, set_valid}, 32'd0);
        check("rst_field", {30'd0, field_sel}, 32'd0);
        check("rst_load", {31'd0, set_load}, 32'd0);

        // first commit from now_date
        now_date = mk_date(2024, 2, 29);
        apply(B_MODE, 2'd1, mk_date(2024, 2, 29), "c_enter");
        apply(B_MODE, 2'd2, mk_date(2024, 2, 29), "c_month");
        apply(B_MODE, 2'd3, mk_date(2024, 2, 29), "c_day");
        apply(B_MODE, 2'd0, mk_date(2024, 2, 29), "c_commit");
        check("c_load_hi", {31'd0, set_load}, 32'd1);
        check("c_set_date", {9'd0, set_date}, {9'd0, mk_date(2024, 2, 29)});
        check("c_valid", {31'd0, set_valid}, 32'd1);
        idle(1, 2'd0, mk_date(2024, 2, 29), "c_after");
        check("c_load_lo", {31'd0, set_load}, 32'd0);
        check("c_load_cnt", load_cnt, 32'd1);

        // second edit seeds from set_date, not now_date
        now_date = mk_date(2030, 5, 5);
        apply(B_MODE, 2'd1, mk_date(2024, 2, 29), "e_enter");
        apply(B_UP,   2'd1, mk_date(2025, 2, 28), "e_year_up_clamp");
        apply(B_MODE, 2'd2, mk_date(2025, 2, 28), "e_to_month");
        apply(B_DN,   2'd2, mk_date(2025, 1, 28), "e_month_dn1");
        apply(B_DN,   2'd2, mk_date(2025, 12, 28), "e_month_wrap");
        apply(B_MODE, 2'd3, mk_date(2025, 12, 28), "e_to_day");
        apply(B_UP,   2'd3, mk_date(2025, 12, 29), "e_day_up1");
        apply(B_UP,   2'd3, mk_date(2025, 12, 30), "e_day_up2");
        apply(B_UP,   2'd3, mk_date(2025, 12, 31), "e_day_up3");
        apply(B_UP,   2'd3, mk_date(2025, 12, 1),  "e_day_wrap");
        apply(B_UP | B_DN, 2'd3, mk_date(2025, 12, 1), "e_updn_ignored");
        apply(B_CAN | B_MODE, 2'd0, mk_date(2025, 12, 1), "e_cancel_mode");
        check("e_set_kept", {9'd0, set_date}, {9'd0, mk_date(2024, 2, 29)});
        check("e_no_load", load_cnt, 32'd1);
        apply(B_UP,  2'd0, mk_date(2025, 12, 1), "idle_up_ignored");
        apply(B_CAN, 2'd0, mk_date(2025, 12, 1), "idle_cancel_ignored");

        // year and month wrap limits
        do_reset(1);
        now_date = mk_date(9999, 1, 15);
        apply(B_MODE, 2'd1, mk_date(9999, 1, 15), "w_enter");
        apply(B_UP,   2'd1, mk_date(1, 1, 15),    "w_year_up_wrap");
        apply(B_DN,   2'd1, mk_date(9999, 1, 15), "w_year_dn_wrap");
        apply(B_MODE, 2'd2, mk_date(9999, 1, 15), "w_to_month");
        apply(B_DN,   2'd2, mk_date(9999, 12, 15), "w_month_dn_wrap");
        apply(B_UP,   2'd2, mk_date(9999, 1, 15), "w_month_up_wrap");
        apply(B_CAN,  2'd0, mk_date(9999, 1, 15), "w_cancel");

        // sanitising out-of-range seeds and leap rule
        now_date = mk_date(12000, 2, 30);
        apply(B_MODE, 2'd1, mk_date(9999, 2, 28), "s_big");
        apply(B_CAN,  2'd0, mk_date(9999, 2, 28), "s_big_cancel");
        now_date = mk_date(0, 13, 31);
        apply(B_MODE, 2'd1, mk_date(1, 12, 31), "s_small");
        apply(B_CAN,  2'd0, mk_date(1, 12, 31), "s_small_cancel");
        now_date = mk_date(1900, 2, 29);
        apply(B_MODE, 2'd1, mk_date(1900, 2, 28), "l_1900");
        apply(B_MODE, 2'd2, mk_date(1900, 2, 28), "l_1900_m");
        apply(B_MODE, 2'd3, mk_date(1900, 2, 28), "l_1900_d");
        apply(B_UP,   2'd3, mk_date(1900, 2, 1),  "l_1900_day_wrap");
        apply(B_DN,   2'd3, mk_date(1900, 2, 28), "l_1900_day_dn_wrap");
        apply(B_CAN,  2'd0, mk_date(1900, 2, 28), "l_1900_cancel");
        now_date = mk_date(2000, 2, 29);
        apply(B_MODE, 2'd1, mk_date(2000, 2, 29), "l_2000");
        apply(B_UP,   2'd1, mk_date(2001, 2, 28), "l_2001_clamp");
        apply(B_CAN,  2'd0, mk_date(2001, 2, 28), "l_cancel");
        check("s_valid_still_0", {31'd0, set_valid}, 32'd0);

        // inactivity timeout
        apply(B_MODE, 2'd1, mk_date(2000, 2, 29), "t_enter");
        idle(15, 2'd1, mk_date(2000, 2, 29), "t_before_expiry");
        idle(1,  2'd0, mk_date(2000, 2, 29), "t_expired");
        apply(B_MODE, 2'd1, mk_date(2000, 2, 29), "t2_enter");
        idle(9,  2'd1, mk_date(2000, 2, 29), "t2_mid");
        apply(B_UP, 2'd1, mk_date(2001, 2, 28), "t2_restart");
        idle(15, 2'd1, mk_date(2001, 2, 28), "t2_before_expiry");
        idle(1,  2'd0, mk_date(2001, 2, 28), "t2_expired");
        check("t_no_load", load_cnt, 32'd1);
        check("t_valid", {31'd0, set_valid}, 32'd0);

        // reset in the middle of an edit
        apply(B_MODE, 2'd1, mk_date(2000, 2, 29), "r_enter");
        apply(B_MODE, 2'd2, mk_date(2000, 2, 29), "r_month");
        apply(B_MODE, 2'd3, mk_date(2000, 2, 29), "r_day");
        do_reset(1);
        check("r_field", {30'd0, field_sel}, 32'd0);
        check("r_set_date", {9'd0, set_date}, {9'd0, mk_date(2000, 1, 1)});
        check("r_work_date", {9'd0, work_date}, {9'd0, mk_date(2000, 1, 1)});
        idle(3, 2'd0, mk_date(2000, 1, 1), "r_idle");
        check("r_no_load", load_cnt, 32'd1);

        // commit after reset works again
        now_date = mk_date(2031, 7, 4);
        apply(B_MODE, 2'd1, mk_date(2031, 7, 4), "f_enter");
        apply(B_MODE, 2'd2, mk_date(2031, 7, 4), "f_month");
        apply(B_MODE, 2'd3, mk_date(2031, 7, 4), "f_day");
        apply(B_MODE, 2'd0, mk_date(2031, 7, 4), "f_commit");
        check("f_set_date", {9'd0, set_date}, {9'd0, mk_date(2031, 7, 4)});
        idle(2, 2'd0, mk_date(2031, 7, 4), "f_after");
        check("f_load_cnt", load_cnt, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dday_set_ctrl.md
DDAY_SET_CTRL -- requirements
Module: dday_set_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, 32'd50_000_000, edit-inactivity cycles before auto-cancel.
REQ-002 Parameter RST_DATE, {14'd2000,4'd1,5'd1}, set_date value after reset.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port btn_mode  input  1  one-cycle pulse; enter edit or advance field.
REQ-006 Port btn_up  input  1  one-cycle pulse; increment selected field.
REQ-007 Port btn_dn  input  1  one-cycle pulse; decrement selected field.
REQ-008 Port btn_cancel  input  1  one-cycle pulse; abandon edit.
REQ-009 Port now_date  input  23  current date, year[22:9] month[8:5] day[4:0].
REQ-010 Port set_date  output  23  committed target date, same packing, feeds the D-day datapath.
REQ-011 Port work_date  output  23  date being edited, for display.
REQ-012 Port field_sel  output  2  0 none, 1 year, 2 month, 3 day.
REQ-013 Port set_valid  output  1  high once any date has been committed since reset.
REQ-014 Port set_load  output  1  one-cycle pulse on each commit.

Function
REQ-015 FSM states SHALL be IDLE, ED_YEAR, ED_MONTH, ED_DAY; field_sel encodes state (IDLE=0).
REQ-016 IDLE + btn_mode SHALL load work_date from set_date if set_valid else from now_date, and go to ED_YEAR next cycle.
REQ-017 btn_mode SHALL advance ED_YEAR->ED_MONTH->ED_DAY; in ED_DAY it SHALL copy work_date to set_date, set set_valid, pulse set_load for exactly one cycle, return to IDLE.
REQ-018 btn_cancel in any edit state SHALL return to IDLE with set_date, set_valid unchanged and no set_load.
REQ-019 Same-cycle priority SHALL be cancel > mode > up/dn; btn_up and btn_dn together SHALL be ignored.
REQ-020 Year SHALL range 1..9999 with wrap (9999 up -> 1, 1 down -> 9999).
REQ-021 Month SHALL range 1..12 with wrap.
REQ-022 Day SHALL range 1..dim(year,month) with wrap; dim uses Gregorian leap rule (div 4, not 100 unless 400).
REQ-023 After any year or month change, day SHALL be clamped to the new dim in the same cycle as the change.
REQ-024 Field edits SHALL take effect on work_date the cycle after the pulse (latency 1); set_date SHALL change only on commit or reset.
REQ-025 Inactivity counter SHALL reset to 0 on any button pulse and on edit entry, count while in an edit state, and at TIMEOUT_CYC-1 force a cancel (REQ-018 behaviour).
REQ-026 Buttons other than btn_mode SHALL be ignored in IDLE; work_date SHALL hold its value in IDLE.
REQ-027 An out-of-range now_date loaded on entry SHALL be sanitised: year/month clamped into range, then day clamped per REQ-023.

Reset
REQ-028 On rst: state IDLE, set_date=RST_DATE, work_date=RST_DATE, set_valid=0, set_load=0, timeout counter 0.
REQ-029 rst asserted mid-edit SHALL discard work_date with no set_load pulse.

Structure
REQ-030 Shared package dcal_pkg SHALL hold date field bit positions/widths, YEAR_MIN/YEAR_MAX, and the state enumeration.
REQ-031 A combinational sub-module days_in_month (year, month -> 5-bit 28..31) SHALL be instantiated; it is reusable by the date-to-days converter.

Verification
REQ-032 Reset, no buttons -> set_date=2000-01-01, set_valid=0, field_sel=0.
REQ-033 now_date=2024-02-29, mode, mode, mode, mode -> set_date=2024-02-29, set_load one cycle, set_valid=1.
REQ-034 Edit from 2024-02-29: ED_YEAR up -> work_date 2025-02-28; ED_MONTH dn x2 -> 2025-12-28; ED_DAY up x4 -> 2025-12-01.
REQ-035 Year 9999 up -> 1; month 1 dn -> 12; simultaneous up+dn -> no change; cancel+mode same cycle -> IDLE, set_date unchanged.
REQ-036 TIMEOUT_CYC=16, enter edit, no buttons 16 cycles -> IDLE, no set_load; pulse at cycle 10 restarts count.
REQ-037 rst asserted in ED_DAY -> next cycle IDLE, set_date=RST_DATE, set_load never pulsed.
